// File: rtl/uart_pkg.sv
// Shared UART definitions: default line timing and the receiver state encoding.
package uart_pkg;

    localparam int UART_OVS = 16;   // clk periods per bit
    localparam int UART_DW  = 8;    // data bits per frame

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop detection with a one-entry
// output buffer, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVS = UART_OVS,
    parameter int DW  = UART_DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rxd,
    output logic [DW-1:0] d_rx,
    output logic          vld_rx,
    input  logic          rdy_rx,
    output logic          err_frame,
    output logic          err_ovr
);

    localparam int CNT_W = $clog2(OVS);
    localparam int IDX_W = $clog2(DW + 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DW - 1);

    logic             rxs;
    rx_state_t        state_r;
    rx_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [DW-1:0]    shift_r;
    logic             good_stop_r;
    logic [DW-1:0]    d_rx_r;
    logic             vld_rx_r;
    logic             err_frame_r;
    logic             err_ovr_r;

    logic half_tick_s;
    logic full_tick_s;
    logic cnt_clr_s;
    logic idx_clr_s;
    logic data_smp_s;
    logic good_stop_s;
    logic bad_stop_s;
    logic load_s;
    logic ovr_s;

    rx_sync u_rx_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rxd),
        .q    (rxs)
    );

    assign half_tick_s = (cnt_r == HALF_M1);
    assign full_tick_s = (cnt_r == FULL_M1);

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= RX_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RX_IDLE: begin
                if (!rxs) state_nxt_s = RX_START;
                else      state_nxt_s = RX_IDLE;
            end
            RX_START: begin
                if (half_tick_s) state_nxt_s = rxs ? RX_IDLE : RX_DATA;
                else             state_nxt_s = RX_START;
            end
            RX_DATA: begin
                if (full_tick_s && (idx_r == LAST_IDX)) state_nxt_s = RX_STOP;
                else                                    state_nxt_s = RX_DATA;
            end
            RX_STOP: begin
                if (full_tick_s) state_nxt_s = rxs ? RX_IDLE : RX_BREAK;
                else             state_nxt_s = RX_STOP;
            end
            RX_BREAK: begin
                if (rxs) state_nxt_s = RX_IDLE;
                else     state_nxt_s = RX_BREAK;
            end
            default: state_nxt_s = RX_IDLE;
        endcase
    end

    // FSM output decode: counter control and sample strobes
    always_comb begin
        cnt_clr_s   = 1'b0;
        idx_clr_s   = 1'b0;
        data_smp_s  = 1'b0;
        good_stop_s = 1'b0;
        bad_stop_s  = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cnt_clr_s = 1'b1;
                idx_clr_s = 1'b1;
            end
            RX_START: begin
                if (half_tick_s) begin
                    cnt_clr_s = 1'b1;
                    idx_clr_s = 1'b1;
                end else begin
                    cnt_clr_s = 1'b0;
                    idx_clr_s = 1'b0;
                end
            end
            RX_DATA: begin
                data_smp_s = full_tick_s;
            end
            RX_STOP: begin
                if (full_tick_s) begin
                    good_stop_s = rxs;
                    bad_stop_s  = !rxs;
                end else begin
                    good_stop_s = 1'b0;
                    bad_stop_s  = 1'b0;
                end
            end
            RX_BREAK: begin
                cnt_clr_s = 1'b1;
            end
            default: begin
                cnt_clr_s = 1'b1;
                idx_clr_s = 1'b1;
            end
        endcase
    end

    // tick counter (wraps each bit period) and data bit index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else begin
            if (cnt_clr_s || full_tick_s) cnt_r <= {CNT_W{1'b0}};
            else                          cnt_r <= cnt_r + CNT_W'(1);
            if (idx_clr_s)       idx_r <= {IDX_W{1'b0}};
            else if (data_smp_s) idx_r <= idx_r + IDX_W'(1);
        end
    end

    // shift register: each data sample lands at bit[idx] (LSB first on the line)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_r <= {DW{1'b0}};
        end else if (data_smp_s) begin
            for (int i = 0; i < DW; i++) begin
                if (idx_r == IDX_W'(i)) shift_r[i] <= rxs;
            end
        end
    end

    // delivery is decided one cycle after the stop sample, against the live handshake
    assign load_s = good_stop_r && (!vld_rx_r || rdy_rx);
    assign ovr_s  = good_stop_r && vld_rx_r && !rdy_rx;

    // output buffer and error pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            good_stop_r <= 1'b0;
            d_rx_r      <= {DW{1'b0}};
            vld_rx_r    <= 1'b0;
            err_frame_r <= 1'b0;
            err_ovr_r   <= 1'b0;
        end else begin
            good_stop_r <= good_stop_s;
            err_frame_r <= bad_stop_s;
            err_ovr_r   <= ovr_s;
            if (load_s) begin
                d_rx_r   <= shift_r;
                vld_rx_r <= 1'b1;
            end else if (vld_rx_r && rdy_rx) begin
                vld_rx_r <= 1'b0;
            end
        end
    end

    assign d_rx      = d_rx_r;
    assign vld_rx    = vld_rx_r;
    assign err_frame = err_frame_r;
    assign err_ovr   = err_ovr_r;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVS, 16, clk periods per bit; even, 4..64.
REQ-002 Parameter: DW, 8, data bits per frame.
REQ-003 Port: clk  input  1  single clock, rising-edge, frequency OVS x baud (153.6 kHz for 9600 baud).
REQ-004 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port: rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-006 Port: d_rx  output  DW  received byte, LSB first on line.
REQ-007 Port: vld_rx  output  1  d_rx valid; held until consumed.
REQ-008 Port: rdy_rx  input  1  consumer ready; byte consumed on the cycle where vld_rx & rdy_rx.
REQ-009 Port: err_frame  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 Port: err_ovr  output  1  one-cycle pulse when a good frame completes while the buffer is still full.

Function
REQ-011 Frame format: start 0, DW data bits LSB first, one stop 1; no parity; matches the team's uart transmitter.
REQ-012 rxd passes through a 2-flop synchronizer; the FSM uses only the synchronized value (rxs).
REQ-013 FSM states: IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rxs==0 -> START, tick counter cleared to 0.
REQ-015 START: at tick OVS/2-1, sample rxs; 0 -> DATA (counter and bit index cleared); 1 -> IDLE (glitch reject, no output).
REQ-016 DATA: sample rxs every OVS ticks; shift into the shift register at bit[idx]; after bit DW-1 -> STOP.
REQ-017 STOP: sample rxs OVS ticks after the last data bit; 1 -> IDLE and deliver; 0 -> BREAK, err_frame pulse, byte discarded.
REQ-018 BREAK: stay until rxs==1, then IDLE; no start detection while in BREAK.
REQ-019 Delivery: on a good stop, if the buffer is empty, or is full and consumed in the same cycle, load d_rx and set vld_rx on the next clk.
REQ-020 Delivery with the buffer full and not consumed: keep the old d_rx/vld_rx, drop the new byte, pulse err_ovr.
REQ-021 Latency: vld_rx rises exactly OVS/2 + (DW+1)*OVS + 3 clks after the rxd falling edge is first sampled; 155 at defaults.
REQ-022 d_rx stays stable while vld_rx is high; vld_rx falls the cycle after the handshake unless a new load occurs.
REQ-023 Back-to-back frames: start detection resumes in IDLE the cycle after the stop sample; no extra idle bit is needed.
REQ-024 The tick counter is $clog2(OVS) bits and wraps at OVS-1; the bit index is $clog2(DW+1) bits.

Reset
REQ-025 Asynchronous rstn low: FSM->IDLE; counters 0; synchronizer flops 1; d_rx 0; vld_rx, err_frame, err_ovr 0.
REQ-026 Reset mid-frame discards the partial byte; after release, the receiver waits in IDLE for a fresh falling edge.
REQ-027 Deassertion is used as-is; no internal reset synchronizer.

Structure
REQ-028 Package uart_pkg: rx_state_t enum, default OVS/DW constants, shared with the transmitter.
REQ-029 One sub-module: rx_sync (2-flop synchronizer, reset value 1).
REQ-030 The shift register, counters and output buffer are inline in uart_rx.

Verification
REQ-031 Frame 0xA5 at 16x, rdy_rx=1 -> d_rx=8'hA5, vld_rx high for 1 clk, 155 clks after the start edge; no error pulses.
REQ-032 Low glitch on rxd of 4 clks in IDLE -> return to IDLE, vld_rx stays 0, no errors.
REQ-033 Frame 0x3C with stop bit forced 0 for 32 clks -> err_frame 1-clk pulse, vld_rx 0, no start detected until rxd high; next frame 0x81 is received correctly.
REQ-034 Frames 0x11 then 0x22 back-to-back, rdy_rx=0 -> d_rx stays 8'h11 with vld_rx held; err_ovr pulses once; after rdy_rx=1, vld_rx drops.
REQ-035 rstn pulsed low during data bit 4 of 0xFF -> all outputs 0 immediately; subsequent frame 0x5A received as 8'h5A.
REQ-036 Continuous frames 0x00, 0xFF, 0x55 with no idle gap and rdy_rx=1 -> three deliveries in order, each exactly 10*OVS clks apart.
